// File: rtl/eta_pkg.sv
// ---------------------------------------------------------------------------
// eta_pkg
// Shared constants for the ETA-I style approximate adder:
//   ETA_WIDTH     - default total operand width
//   ETA_SPLIT     - default width of the inaccurate low part
//   ETA_RST_BIT   - value every bit of the result register takes in reset
//   ETA_VALID_RST - value of the output-valid flag in reset
// ---------------------------------------------------------------------------
package eta_pkg;

    localparam int   ETA_WIDTH     = 32;
    localparam int   ETA_SPLIT     = 16;
    localparam logic ETA_RST_BIT   = 1'b0;
    localparam logic ETA_VALID_RST = 1'b0;

endpackage : eta_pkg

// File: rtl/etai32_adder_if.sv
// ---------------------------------------------------------------------------
// etai32_adder_if
// Operand / result bundle of the approximate adder.
//   in_valid  - operands on a_i/b_i are valid this cycle   (master -> slave)
//   a_i, b_i  - WIDTH-bit operands                         (master -> slave)
//   out_valid - sum_o holds a fresh result                 (slave -> master)
//   sum_o     - WIDTH+1-bit approximate sum, MSB = carry    (slave -> master)
// ---------------------------------------------------------------------------
interface etai32_adder_if #(
    parameter int WIDTH = eta_pkg::ETA_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             out_valid;
    logic [WIDTH:0]   sum_o;

    modport master (
        output in_valid,
        output a_i,
        output b_i,
        input  out_valid,
        input  sum_o
    );

    modport slave (
        input  in_valid,
        input  a_i,
        input  b_i,
        output out_valid,
        output sum_o
    );
endinterface : etai32_adder_if

// File: rtl/eta_lsb_block.sv
// ---------------------------------------------------------------------------
// eta_lsb_block
// Inaccurate low part of the adder. Walks from the MSB down: bits above the
// first position where both operands are 1 are a XOR b; from that position
// downwards every result bit is forced to 1. Never produces a carry.
//   a_i, b_i - SPLIT-bit low operand slices
//   sum_o    - SPLIT-bit approximate low sum
// ---------------------------------------------------------------------------
module eta_lsb_block #(
    parameter int SPLIT = eta_pkg::ETA_SPLIT
) (
    input  logic [SPLIT-1:0] a_i,
    input  logic [SPLIT-1:0] b_i,
    output logic [SPLIT-1:0] sum_o
);

    // Ripple "set-one" flag travelling MSB -> LSB, carry-chain style.
    logic set_flag;

    always_comb begin
        sum_o    = '0;
        set_flag = 1'b0;
        for (int i = SPLIT - 1; i >= 0; i--) begin
            set_flag = set_flag | (a_i[i] & b_i[i]);
            // Where both bits are 1 the XOR is 0, so the flag supplies the 1.
            sum_o[i] = set_flag | (a_i[i] ^ b_i[i]);
        end
    end

endmodule : eta_lsb_block

// File: rtl/etai32_adder.sv
// ---------------------------------------------------------------------------
// etai32_adder
// Approximate (ETA-I) adder with a single output register stage.
// High part (WIDTH-1..SPLIT) is an exact adder with carry-in tied to 0;
// low part (SPLIT-1..0) comes from eta_lsb_block and never carries upward.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears result and valid
//   bus   - etai32_adder_if slave: in_valid/a_i/b_i in, out_valid/sum_o out
// Latency one cycle; sum_o holds on idle cycles while out_valid drops.
// ---------------------------------------------------------------------------
module etai32_adder
    import eta_pkg::*;
#(
    parameter int WIDTH = ETA_WIDTH,
    parameter int SPLIT = ETA_SPLIT
) (
    input  logic          clk,
    input  logic          rst_n,
    etai32_adder_if.slave bus
);

    localparam int HI_W = WIDTH - SPLIT;

    logic [HI_W:0]    hi_sum;
    logic [SPLIT-1:0] lo_sum;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;
    logic             valid_d;
    logic             valid_q;

    // Exact high part; its carry-out lands in sum bit WIDTH.
    assign hi_sum = {1'b0, bus.a_i[WIDTH-1:SPLIT]} + {1'b0, bus.b_i[WIDTH-1:SPLIT]};

    eta_lsb_block #(
        .SPLIT (SPLIT)
    ) u_lsb (
        .a_i   (bus.a_i[SPLIT-1:0]),
        .b_i   (bus.b_i[SPLIT-1:0]),
        .sum_o (lo_sum)
    );

    always_comb begin
        sum_d   = sum_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d = {hi_sum, lo_sum};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {(WIDTH + 1){ETA_RST_BIT}};
            valid_q <= ETA_VALID_RST;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sum_o     = sum_q;
    assign bus.out_valid = valid_q;

endmodule : etai32_adder

// File: tb/tb_etai32_adder.sv
// ---------------------------------------------------------------------------
// tb_etai32_adder
// Random and directed stimulus against a behavioural model of the
// approximate adder; a negedge process compares DUT outputs every cycle.
// ---------------------------------------------------------------------------
module tb_etai32_adder;

    localparam int W = 32;
    localparam int S = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [W:0] exp_sum;
    logic       exp_valid;

    etai32_adder_if #(.WIDTH(W)) bus ();

    etai32_adder #(
        .WIDTH (W),
        .SPLIT (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural result: exact high-part sum, low part is XOR above the
    // highest both-ones position and all ones from there down.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-S:0]   hi;
        logic [S-1:0]   g;
        logic [S-1:0]   x;
        logic [S-1:0]   m;
        logic [63:0]    mm;
        int             p;
        hi = {1'b0, a[W-1:S]} + {1'b0, b[W-1:S]};
        g  = a[S-1:0] & b[S-1:0];
        x  = a[S-1:0] ^ b[S-1:0];
        if (g == '0) return {hi, x};
        p = 0;
        for (int i = 0; i < S; i++) if (g[i]) p = i;
        mm = (64'd2 << p) - 64'd1;
        m  = mm[S-1:0];
        return {hi, (x & ~m) | m};
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference state, updated on the same events as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sum   <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= bus.in_valid;
            if (bus.in_valid) exp_sum <= model(bus.a_i, bus.b_i);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("out_valid", {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, exp_valid});
        check("sum_o", bus.sum_o, exp_sum);
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.a_i      = a;
        bus.b_i      = b;
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W:0] req);
        drive(1'b1, a, b);
        @(posedge clk); #1;
        check({name, "_dut"}, bus.sum_o, req);
        check({name, "_valid"}, {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, 1'b1});
        $display("[TB] %s a=0x%08h b=0x%08h sum=0x%09h", name, a, b, bus.sum_o);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   held;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(1'b0, '0, '0);
        #1 rst_n = 1'b0;

        // Pin the model with hand-computed values.
        check("model_25", model(32'h00010000, 32'h00010000), 33'h0_00020000);
        check("model_26", model(32'h0000FFFF, 32'h00000001), 33'h0_0000FFFF);
        check("model_27", model(32'h00008000, 32'h00008000), 33'h0_0000FFFF);
        check("model_28", model(32'hFFFF0000, 32'h00010000), 33'h1_00000000);
        check("model_29", model(32'h12340F0F, 32'h11110070), 33'h0_23450F7F);
        check("model_lsb", model(32'h00000005, 32'h00000004), 33'h0_00000007);

        // Reset state while held.
        #20;
        check("reset_sum", bus.sum_o, '0);
        check("reset_valid", {{W{1'b0}}, bus.out_valid}, '0);
        @(negedge clk); rst_n = 1'b1;

        @(posedge clk); #1;
        directed("req25", 32'h00010000, 32'h00010000, 33'h0_00020000);
        directed("req26", 32'h0000FFFF, 32'h00000001, 33'h0_0000FFFF);
        directed("req27", 32'h00008000, 32'h00008000, 33'h0_0000FFFF);
        directed("req28", 32'hFFFF0000, 32'h00010000, 33'h1_00000000);
        directed("req29", 32'h12340F0F, 32'h11110070, 33'h0_23450F7F);

        // Idle cycle: value held, valid dropped.
        held = bus.sum_o;
        drive(1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("hold_sum", bus.sum_o, held);
        check("hold_valid", {{W{1'b0}}, bus.out_valid}, '0);
        $display("[TB] idle sum=0x%09h valid=%0b", bus.sum_o, bus.out_valid);

        // Randomised stream with a mid-stream reset pulse.
        for (int n = 0; n < 600; n++) begin
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b[S-1:0] = ~a[S-1:0];               // no low generate
                1: begin a[S-1:0] = 16'hFFFF; b[S-1:0] = 16'hFFFF; end
                2: begin a[W-1:S] = '1; end            // high carry likely
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, a, b);
            @(posedge clk); #1;
            if (n == 300) begin
                drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
                #1 rst_n = 1'b0;
                #1;
                check("async_rst_sum", bus.sum_o, '0);
                check("async_rst_valid", {{W{1'b0}}, bus.out_valid}, '0);
                $display("[TB] reset pulse sum=0x%09h valid=%0b", bus.sum_o, bus.out_valid);
                @(negedge clk); #1 rst_n = 1'b1;
                @(posedge clk); #1;
                check("post_rst_sum", bus.sum_o, model(32'hFFFFFFFF, 32'hFFFFFFFF));
                check("post_rst_valid", {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, 1'b1});
            end
        end

        drive(1'b0, '0, '0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_etai32_adder

// File: doc/etai32_adder.md
ETAI32_ADDER -- requirements
Module: etai32_adder

Interface
REQ-001 Parameter WIDTH, default 32, total operand width in bits.
REQ-002 Parameter SPLIT, default 16, width of the inaccurate low part; the accurate high part is WIDTH-SPLIT bits; legal range 1..WIDTH-1.
REQ-003 Clk  input  1  rising-edge clock; the block has exactly one clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands on a_i/b_i are valid this cycle.
REQ-006 a_i  input  WIDTH  operand A, two's-complement bit pattern.
REQ-007 b_i  input  WIDTH  operand B, two's-complement bit pattern.
REQ-008 out_valid  output  1  sum_o holds a result.
REQ-009 sum_o  output  WIDTH+1  approximate sum: bit WIDTH is carry-out of the accurate part, bits WIDTH-1..0 are the sum bits.

Function
REQ-010 Operand split: high part is bits WIDTH-1..SPLIT; low part is bits SPLIT-1..0.
REQ-011 High part: exact unsigned addition of a_i and b_i high parts, carry-in fixed at 0 (no carry from the low part); the result goes to sum_o[WIDTH-1:SPLIT] and its carry-out to sum_o[WIDTH].
REQ-012 Low part, per bit from SPLIT-1 down to 0: while no higher low-part position has had a_i=b_i=1, result bit = a_i XOR b_i.
REQ-013 At the first (most significant) low-part position where a_i=b_i=1, that result bit and every lower result bit are 1.
REQ-014 If no low-part position has a_i=b_i=1, the low result equals a_i XOR b_i, which is also the exact low sum.
REQ-015 The low part never generates a carry into the high part.
REQ-016 Latency is one cycle: on a rising Clk with in_valid=1, sum_o is loaded with the result for that cycle's a_i/b_i and out_valid is set to 1.
REQ-017 On a rising Clk with in_valid=0, sum_o holds its value and out_valid is cleared to 0.
REQ-018 There is no backpressure; a new operand pair is accepted on every cycle with in_valid=1.
REQ-019 The approximation is fixed: sign is not treated specially, and overflow past bit WIDTH-1 appears only in sum_o[WIDTH].

Reset
REQ-020 While rst_n=0, sum_o=0 and out_valid=0, asynchronously and regardless of Clk.
REQ-021 An operation in flight when rst_n falls is discarded; the first result after rst_n rises comes from the first in_valid=1 edge after release.

Structure
REQ-022 WIDTH/SPLIT defaults and the output-register reset value live in a shared package, eta_pkg.
REQ-023 The low-part logic is one sub-module, eta_lsb_block, parameterised by SPLIT, implemented as a ripple control chain from MSB to LSB (carry-chain style "set-one" flag); the high part is a plain adder inside the top.
REQ-024 The datapath is combinational between the input ports and a single output register stage.

Verification
REQ-025 a_i=0x00010000, b_i=0x00010000, in_valid=1 -> next cycle sum_o=0x0_00020000, out_valid=1.
REQ-026 a_i=0x0000FFFF, b_i=0x00000001 -> sum_o=0x0_0000FFFF (exact value would be 0x00010000; this shows the low part has no carry).
REQ-027 a_i=0x00008000, b_i=0x00008000 -> sum_o=0x0_0000FFFF (the MSB of the low part has both bits set, so all low bits are 1).
REQ-028 a_i=0xFFFF0000, b_i=0x00010000 -> sum_o=0x1_00000000 (high-part carry-out).
REQ-029 a_i=0x12340F0F, b_i=0x11110070 -> sum_o=0x0_23450F7F (no generate in the low part, so the result is exact).
REQ-030 Pulse rst_n=0 mid-stream with in_valid=1 -> sum_o=0 and out_valid=0 immediately without waiting for Clk; after release, the next valid pair gives the correct result one cycle later.
